// File: rtl/lamp_pkg.sv
// lamp_pkg: lamp vector width, PWM resolution and helpers shared by the
// pattern sequencer and the lamp fade driver.
package lamp_pkg;
    localparam int N_LAMPS_DEF  = 8;
    localparam int PWM_BITS_DEF = 4;

    typedef logic [N_LAMPS_DEF-1:0] lamp_vec_t;

    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction
endpackage

// File: rtl/lamp_fade_channel.sv
// lamp_fade_channel: one lamp's brightness level, fading one step per tick
// toward full or off, rendered as PWM against the shared counter.
module lamp_fade_channel
    import lamp_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                target,
    input  logic                fade_tick,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                mismatch
);
    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

    logic [PWM_BITS-1:0] level_q, level_d, tgt;
    logic                led_q, led_d;

    always_comb begin
        tgt     = target ? MAX : '0;
        level_d = bypass ? tgt :
                  !fade_tick ? level_q :
                  level_q < tgt ? level_q + 1'b1 :
                  level_q > tgt ? level_q - 1'b1 : level_q;
        // Full level is forced on so that MAX really is 100% duty.
        led_d   = bypass ? target : (level_q == MAX) | (level_q > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led      = led_q;
    assign mismatch = level_q != tgt;
endmodule

// File: rtl/lamp_fade_driver.sv
// lamp_fade_driver: turns the sequencer's on/off lamp vector into faded,
// PWM-driven LED outputs, with a bypass that passes the pattern straight through.
module lamp_fade_driver
    import lamp_pkg::*;
#(
    parameter int N_LAMPS  = N_LAMPS_DEF,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int FADE_DIV = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LAMPS-1:0] lamb,
    input  logic               bypass,
    output logic [N_LAMPS-1:0] led,
    output logic               busy
);
    localparam int PRE_W = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [N_LAMPS-1:0]  lamb_q, mismatch;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                fade_tick;

    always_comb begin
        fade_tick = pre_q == PRE_LAST;
        pre_d     = fade_tick ? '0 : pre_q + 1'b1;
        pwm_d     = pwm_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamb_q <= '0;
            pwm_q  <= '0;
            pre_q  <= '0;
        end else begin
            lamb_q <= lamb;
            pwm_q  <= pwm_d;
            pre_q  <= pre_d;
        end
    end

    for (genvar i = 0; i < N_LAMPS; i++) begin : g_ch
        lamp_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .target   (lamb_q[i]),
            .fade_tick(fade_tick),
            .bypass   (bypass),
            .pwm_cnt  (pwm_q),
            .led      (led[i]),
            .mismatch (mismatch[i])
        );
    end

    assign busy = |mismatch;
endmodule
